// File: rtl/spi_instr_loader.sv
// spi_instr_loader
//   SPI-slave (mode 0) loader. Receives a header byte plus one or more program
//   words from a host and writes them into the PIO instruction register file,
//   auto-incrementing the address (wrapping) for every word in a burst.
//   Sticky error flags are reported to the host as a status byte on MISO.
//
// Ports
//   clk         core clock, all logic on rising edge (must be >= 8x spi_sclk)
//   rst         synchronous active-high reset
//   spi_sclk    SPI clock, asynchronous to clk
//   spi_cs_n    SPI chip select, active low
//   spi_mosi    host data, MSB first
//   spi_miso    status byte {4'b1010, 2'b00, parity_err, opcode_err}, MSB first
//   write_addr  regfile write address (held between strobes)
//   write_data  regfile write data (held between strobes)
//   write_en    one-cycle regfile write strobe
//   loading     high while a transaction is active (state != IDLE)
//   err         OR of the sticky error flags
//
// Build option
//   SPI_LOADER_PARITY_EN  each data word is followed by an odd-parity bit;
//                         a word with bad parity is not written but still
//                         consumes its address.
//
// state  | meaning
// IDLE   | no transaction; waiting for cs_n to fall
// HDR    | shifting the 8-bit header (opcode + start address)
// DATA   | shifting one data word (plus parity bit if enabled)
// COMMIT | one cycle: write the word, post-increment the address
// DRAIN  | ignoring bits until cs_n rises (bad opcode or frame cut by reset)

module spi_instr_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  output logic              loading,
  output logic              err
);

`ifdef SPI_LOADER_PARITY_EN
  localparam int WORD_BITS = DATA_W + 1;
`else
  localparam int WORD_BITS = DATA_W;
`endif
  localparam int         CNT_W    = $clog2(WORD_BITS);
  localparam logic [2:0] OP_WRITE = 3'b101;

  typedef enum logic [2:0] {IDLE, HDR, DATA, COMMIT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [1:0]           sclk_sync, cs_sync, mosi_sync;
  logic                 sclk_d, cs_d;
  logic                 sclk_rise, sclk_fall, cs_high, cs_fall, mosi_s;
  logic [WORD_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 bit_last;
  logic [7:0]           hdr;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    word;
  logic                 parity_ok;
  logic                 opcode_err, parity_err, opc_set, par_set;
  logic                 rep_opc, rep_par, status_done;
  logic [7:0]           status, miso_sh;
  logic [3:0]           miso_left;

  // The cs_n chain resets to "selected" so that a frame still in progress
  // when reset releases is never seen as a fresh falling edge; IDLE then
  // routes it to DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_high   = cs_sync[1];
  assign cs_fall   = cs_d & ~cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign bit_last  = (bit_cnt == '0);
  assign hdr       = {shreg[6:0], mosi_s};
  assign loading   = (state != IDLE);
  assign err       = opcode_err | parity_err;

`ifdef SPI_LOADER_PARITY_EN
  assign word      = shreg[WORD_BITS-1:1];
  assign parity_ok = ^shreg;
  assign par_set   = (state == COMMIT) && !parity_ok;
`else
  assign word      = shreg;
  assign parity_ok = 1'b1;
  assign par_set   = 1'b0;
`endif

  assign opc_set = (state == HDR) && sclk_rise && bit_last && (hdr[7:5] != OP_WRITE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!cs_high) state_nxt = cs_fall ? HDR : DRAIN;
      HDR:     if (sclk_rise && bit_last)
                 state_nxt = (hdr[7:5] == OP_WRITE) ? DATA : DRAIN;
      DATA:    if (sclk_rise && bit_last) state_nxt = COMMIT;
      COMMIT:  state_nxt = DATA;
      DRAIN:   state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
    if (cs_high) state_nxt = IDLE;
  end

  // Bit counter is a down-counter; terminal count 0 marks the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= CNT_W'(7);
      addr       <= '0;
      write_addr <= '0;
      write_data <= '0;
      write_en   <= 1'b0;
    end else begin
      write_en <= 1'b0;
      case (state)
        IDLE: bit_cnt <= CNT_W'(7);
        HDR, DATA: begin
          if (sclk_rise) begin
            shreg   <= {shreg[WORD_BITS-2:0], mosi_s};
            bit_cnt <= bit_last ? CNT_W'(WORD_BITS - 1) : bit_cnt - CNT_W'(1);
            if (state == HDR && bit_last) addr <= ADDR_W'(hdr[4:0]);
          end
        end
        COMMIT: begin
          if (parity_ok) begin
            write_en   <= 1'b1;
            write_addr <= addr;
            write_data <= word;
          end
          addr <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign status      = {4'b1010, 2'b00, parity_err, opcode_err};
  assign status_done = !cs_high && !cs_fall && sclk_fall && (miso_left == 4'd1);

  // Only the flags that were actually reported in this frame's status byte
  // are cleared, so an error raised during the frame survives to the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_miso   <= 1'b0;
      miso_sh    <= '0;
      miso_left  <= '0;
      rep_opc    <= 1'b0;
      rep_par    <= 1'b0;
      opcode_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (cs_high) begin
        spi_miso  <= 1'b0;
        miso_left <= '0;
      end else if (cs_fall) begin
        spi_miso  <= status[7];
        miso_sh   <= {status[6:0], 1'b0};
        miso_left <= 4'd8;
        rep_opc   <= opcode_err;
        rep_par   <= parity_err;
      end else if (sclk_fall && miso_left != '0) begin
        spi_miso  <= miso_sh[7];
        miso_sh   <= {miso_sh[6:0], 1'b0};
        miso_left <= miso_left - 4'd1;
      end
      opcode_err <= (opcode_err & ~(status_done & rep_opc)) | opc_set;
      parity_err <= (parity_err & ~(status_done & rep_par)) | par_set;
    end
  end

endmodule

// File: tb/tb_spi_instr_loader.sv
// tb_spi_instr_loader
//   Self-checking bench for spi_instr_loader. A frame-level reference model
//   predicts regfile writes (address, data, strobe cycle), the MISO status
//   byte and the sticky error flags; expected writes go into a queue that an
//   independent monitor drains whenever write_en is seen.
//   Define SPI_LOADER_PARITY_EN for both bench and RTL to exercise parity.

module tb_spi_instr_loader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
`ifdef SPI_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int WB = DATA_W + int'(PAR);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              spi_sclk = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              loading;
  logic              err;

  spi_instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .write_addr(write_addr),
    .write_data(write_data), .write_en(write_en), .loading(loading), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                at;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        m_opc = 1'b0;
  logic        m_par = 1'b0;
  logic [15:0] words[8];
  logic        bad_par[8];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest predicted write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst && write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", write_addr, write_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", write_addr, e.addr);
        check("write_data", write_data, e.data);
        check("write_cycle", cyc, e.at);
        check("loading_on_write", loading, 1);
      end
    end
  end

  // One SPI bit: host drives MOSI while sclk low, samples MISO at the rise.
  task automatic spi_bit(input logic b, input logic push, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output logic mi);
    wr_t e;
    spi_mosi = b;
    wait_clk(4);
    mi = spi_miso;
    spi_sclk = 1'b1;
    if (push) begin
      e.addr = a;
      e.data = d;
      e.at   = cyc + 4;
      exp_q.push_back(e);
    end
    wait_clk(4);
    spi_sclk = 1'b0;
  endtask

  // abort_bits >= 0 cuts the last word after that many bits.
  task automatic do_frame(input logic [7:0] hdr, input int nw, input int abort_bits);
    logic [7:0]        st_got, st_exp;
    logic              mi, rep_opc, rep_par, new_opc, new_par, valid, bval, good;
    logic [ADDR_W-1:0] a;
    logic [15:0]       w;
    int                nb;
    st_exp  = {4'hA, 2'b00, m_par, m_opc};
    rep_opc = m_opc;
    rep_par = m_par;
    new_par = 1'b0;
    valid   = (hdr[7:5] == 3'b101);
    new_opc = !valid;
    a       = hdr[4:0];
    spi_cs_n = 1'b0;
    wait_clk(4);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(hdr[i], 1'b0, '0, '0, mi);
      st_got[i] = mi;
    end
    check("miso_status", st_got, st_exp);
    check("loading_active", loading, 1);
    for (int k = 0; k < nw; k++) begin
      w  = words[k];
      nb = (abort_bits >= 0 && k == nw - 1) ? abort_bits : WB;
      for (int j = 0; j < nb; j++) begin
        bval = (j < DATA_W) ? w[DATA_W-1-j] : (~(^w) ^ bad_par[k]);
        good = valid && (j == WB - 1) && !(PAR && bad_par[k]);
        spi_bit(bval, good, a, w, mi);
      end
      if (nb == WB) begin
        if (valid && PAR && bad_par[k]) new_par = 1'b1;
        a = a + 1'b1;
      end
    end
    wait_clk(2);
    spi_cs_n = 1'b1;
    wait_clk(6);
    m_opc = (m_opc & ~rep_opc) | new_opc;
    m_par = (m_par & ~rep_par) | new_par;
    check("err_after_frame", err, m_opc | m_par);
    check("loading_idle", loading, 0);
  endtask

  task automatic clear_bad();
    for (int i = 0; i < 8; i++) bad_par[i] = 1'b0;
  endtask

  task automatic reset_mid_frame();
    logic       mi;
    logic [7:0] h;
    h = 8'hA5;
    spi_cs_n = 1'b0;
    wait_clk(4);
    for (int i = 7; i >= 0; i--) spi_bit(h[i], 1'b0, '0, '0, mi);
    for (int j = 0; j < 5; j++) spi_bit(1'b1, 1'b0, '0, '0, mi);
    rst = 1'b1;
    wait_clk(2);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
    check("rst_write_en", write_en, 0);
    check("rst_loading", loading, 0);
    check("rst_err", err, 0);
    check("rst_miso", spi_miso, 0);
    rst = 1'b0;
    m_opc = 1'b0;
    m_par = 1'b0;
    wait_clk(3);
    check("drain_after_rst", loading, 1);
    for (int j = 5; j < WB; j++) spi_bit(1'b1, 1'b0, '0, '0, mi);
    wait_clk(2);
    spi_cs_n = 1'b1;
    wait_clk(6);
    check("idle_after_drain", loading, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    wait_clk(3);
    check("reset_write_addr", write_addr, 0);
    check("reset_write_data", write_data, 0);
    check("reset_write_en", write_en, 0);
    check("reset_loading", loading, 0);
    check("reset_err", err, 0);
    check("reset_miso", spi_miso, 0);
    rst = 1'b0;
    wait_clk(4);

    clear_bad();
    words[0] = 16'h1234;
    do_frame(8'hA3, 1, -1);

    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
    do_frame(8'hBE, 3, -1);

    words[0] = 16'hFFFF;
    do_frame(8'h43, 1, -1);
    check("err_bad_opcode", err, 1);

    words[0] = 16'h00C5;
    do_frame(8'hA0, 1, -1);
    check("err_cleared", err, 0);

    words[0] = 16'hABCD;
    do_frame(8'hA7, 1, 9);

    if (PAR) begin
      words[0] = 16'h0001; bad_par[0] = 1'b1;
      words[1] = 16'h0002;
      do_frame(8'hA4, 2, -1);
      clear_bad();
    end

    words[0] = 16'h5A5A;
    do_frame(8'h61, 1, -1);
    reset_mid_frame();
    words[0] = 16'hBEEF; words[1] = 16'hCAFE;
    do_frame(8'hBF, 2, -1);

    for (int r = 0; r < 24; r++) begin
      logic [2:0] op;
      int         nw, ab;
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b101;
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++) begin
        words[k]   = 16'($urandom);
        bad_par[k] = ($urandom_range(0, 3) == 0);
      end
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, WB - 1) : -1;
      do_frame({op, 5'($urandom_range(0, 31))}, nw, ab);
    end

    wait_clk(10);
    check("pending_writes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
